// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, DEPTH-entry {pc, instr} queue, redirect flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr_i,
  output logic [XLEN-1:0] next_pc_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_instr_o,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [XLEN-1:0]   mem_pc_q    [DEPTH];
  logic [XLEN-1:0]   mem_instr_q [DEPTH];

  logic gnt_s;
  logic push_s;
  logic pop_s;

  assign imem_addr_o = pc_addr_i;
  assign gnt_s       = imem_req_o && imem_gnt_i;
  assign dec_valid_o = (count_q != {CW{1'b0}});
  assign pop_s       = dec_valid_o && dec_ready_i && !redirect_valid_i;
  assign dec_pc_o    = mem_pc_q[head_q];
  assign dec_instr_o = mem_instr_q[head_q];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a late response always returns WAIT/DROP to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = IDLE;
      IDLE: begin
        if (gnt_s) state_d = WAIT;
        else       state_d = IDLE;
      end
      WAIT: begin
        if (imem_rvalid_i)         state_d = IDLE;
        else if (redirect_valid_i) state_d = DROP;
        else                       state_d = WAIT;
      end
      DROP: begin
        if (imem_rvalid_i) state_d = IDLE;
        else               state_d = DROP;
      end
      default: state_d = BOOT;
    endcase
  end

  // Output logic: request, next PC and queue push
  always_comb begin
    imem_req_o = 1'b0;
    next_pc_o  = pc_addr_i;
    push_s     = 1'b0;
    case (state_q)
      BOOT: next_pc_o = RESET_PC;
      IDLE: begin
        imem_req_o = !redirect_valid_i && (count_q < DEPTH_C);
        if (imem_req_o && imem_gnt_i) next_pc_o = pc_addr_i + XLEN'(4);
        else                          next_pc_o = pc_addr_i;
      end
      WAIT:    push_s = imem_rvalid_i && !redirect_valid_i;
      DROP:    push_s = 1'b0;
      default: next_pc_o = pc_addr_i;
    endcase
    if (redirect_valid_i) next_pc_o = {redirect_target_i[XLEN-1:2], 2'b00};
    else                  next_pc_o = next_pc_o;
  end

  // Queue pointer/occupancy next state; redirect flush has priority over push/pop
  always_comb begin
    req_pc_d = gnt_s ? pc_addr_i : req_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (redirect_valid_i) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) tail_d = tail_q + AW'(1);
      else        tail_d = tail_q;
      if (pop_s)  head_d = head_q + AW'(1);
      else        head_d = head_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q <= {XLEN{1'b0}};
      head_q   <= {AW{1'b0}};
      tail_q   <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      req_pc_q <= req_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // Queue storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= {XLEN{1'b0}};
        mem_instr_q[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      mem_pc_q[tail_q]    <= req_pc_q;
      mem_instr_q[tail_q] <= imem_rdata_i;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Pushes and decode-starved cycles, both wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {31'd0, push_s};
      stall_cnt_q <= stall_cnt_q + {31'd0, dec_ready_i && !dec_valid_o};
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_fetch_cnt_o = 32'd0;
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against
// a program-order reference model (expected fetch/decode PCs and queue occupancy).
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  // memory responder state (driven only from cyc)
  bit          mem_gnt;
  int          mem_lat;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] slow_addr;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .pc_addr_i(pc_reg), .next_pc_o(next_pc),
    .redirect_valid_i(redirect_valid), .redirect_target_i(redirect_target),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .dec_pc_o(dec_pc), .dec_instr_o(dec_instr),
    .perf_fetch_cnt_o(perf_fetch_cnt), .perf_stall_cnt_o(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external PC register
  always @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= 32'hFFFF_FFFC;
    else     pc_reg <= next_pc;
  end

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One cycle: drive inputs at negedge, let combinational outputs settle, update the memory model.
  // rdy_mode: 0 = not ready, 1 = ready, 2 = ready exactly when dec_valid
  task automatic cyc(input bit redir, input logic [31:0] tgt, input int rdy_mode);
    @(negedge clk);
    redirect_valid  = redir;
    redirect_target = tgt;
    dec_ready       = (rdy_mode == 2) ? dec_valid : (rdy_mode == 1);
    imem_gnt        = mem_gnt;
    imem_rvalid     = (pend_cnt == 1);
    if (imem_rvalid) imem_rdata = (pend_addr == slow_addr) ? 32'h0000_0013 : f(pend_addr);
    else             imem_rdata = 32'hDEAD_BEEF;
    #1;
    if (imem_rvalid)       pend_cnt = 0;
    else if (pend_cnt > 1) pend_cnt = pend_cnt - 1;
    if (imem_req && imem_gnt) begin
      pend_cnt  = (imem_addr == slow_addr) ? 3 : mem_lat;
      pend_addr = imem_addr;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0; dec_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pend_cnt = 0; mem_gnt = 1'b0; mem_lat = 1; slow_addr = 32'h1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0; dec_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pend_cnt = 0; mem_gnt = 1'b0; mem_lat = 1; slow_addr = 32'h1;
    repeat (2) @(negedge clk);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got valid=%b req=%b exp 0 0", dec_valid, imem_req);
    end
    checks++;
    if (next_pc !== RESET_PC) begin
      errors++; $display("FAIL reset_next_pc got %h exp %h", next_pc, RESET_PC);
    end
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d %0d exp 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
    rst = 1'b0;
    cyc(1'b0, 32'h0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_first_req got req=%b addr=%h exp 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] ea, ep;
    int np;
    do_reset();
    mem_gnt = 1'b1; ea = RESET_PC; ep = RESET_PC; np = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 32'h0, 1);
      if (imem_req && imem_gnt) begin
        checks++;
        if (imem_addr !== ea) begin errors++; $display("FAIL seq_addr got %h exp %h", imem_addr, ea); end
        ea = ea + 32'd4;
      end
      if (dec_valid) begin
        checks++;
        if (dec_pc !== ep || dec_instr !== f(ep)) begin
          errors++; $display("FAIL seq_dec got %h/%h exp %h/%h", dec_pc, dec_instr, ep, f(ep));
        end
        ep = ep + 32'd4; np++;
      end
    end
    checks++;
    if (np < 10) begin errors++; $display("FAIL seq_pops got %0d exp >=10", np); end
  endtask

  task automatic test_fill();
    int ng;
    do_reset();
    mem_gnt = 1'b1; ng = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, 32'h0, 0);
      if (imem_req && imem_gnt) begin
        checks++;
        if (imem_addr !== 32'(ng * 4)) begin errors++; $display("FAIL fill_addr got %h exp %h", imem_addr, ng * 4); end
        ng++;
      end
    end
    checks++;
    if (ng != DEPTH) begin errors++; $display("FAIL fill_grants got %0d exp %0d", ng, DEPTH); end
    checks++;
    if (imem_req !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
      errors++; $display("FAIL fill_full got req=%b valid=%b pc=%h exp 0 1 0", imem_req, dec_valid, dec_pc);
    end
    cyc(1'b0, 32'h0, 1);
    cyc(1'b0, 32'h0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL fill_after_pop got req=%b addr=%h exp 1 10", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit found, seen;
    do_reset();
    mem_gnt = 1'b1; slow_addr = 32'h8; found = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 32'h0, 1);
      if (imem_req && imem_gnt && imem_addr == 32'h8) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rdw_grant got none exp grant at 8"); end
    cyc(1'b1, 32'h100, 1);
    checks++;
    if (next_pc !== 32'h100 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rdw_redirect got next_pc=%h req=%b exp 100 0", next_pc, imem_req);
    end
    cyc(1'b0, 32'h0, 1);
    cyc(1'b0, 32'h0, 1);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rdw_drop got valid=%b req=%b exp 0 0", dec_valid, imem_req);
    end
    cyc(1'b0, 32'h0, 1);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL rdw_refetch got valid=%b req=%b addr=%h exp 0 1 100", dec_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(1'b0, 32'h0, 1);
      if (dec_valid) begin
        seen = 1'b1;
        checks++;
        if (dec_pc !== 32'h100 || dec_instr !== f(32'h100)) begin
          errors++; $display("FAIL rdw_first_dec got %h/%h exp 100/%h", dec_pc, dec_instr, f(32'h100));
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rdw_timeout got no dec_valid exp dec at 100"); end
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    do_reset();
    mem_gnt = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 32'h0, 0);
      if (imem_req && imem_gnt && imem_addr == 32'h4) found = 1'b1;
    end
    cyc(1'b1, 32'h103, 1);
    checks++;
    if (!found || imem_rvalid !== 1'b1 || dec_valid !== 1'b1 || next_pc !== 32'h100) begin
      errors++; $display("FAIL rrv_setup got found=%b rvalid=%b valid=%b next_pc=%h exp 1 1 1 100", found, imem_rvalid, dec_valid, next_pc);
    end
    cyc(1'b0, 32'h0, 0);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL rrv_after got valid=%b req=%b addr=%h exp 0 1 100", dec_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    mem_gnt = 1'b1; slow_addr = 32'hC; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 32'h0, 0);
      if (imem_req && imem_gnt && imem_addr == 32'hC) found = 1'b1;
    end
    cyc(1'b0, 32'h0, 0);
    checks++;
    if (!found || dec_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_setup got found=%b valid=%b exp 1 1", found, dec_valid);
    end
    rst = 1'b1; pend_cnt = 0;
    #1;
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rmid_async got valid=%b req=%b exp 0 0", dec_valid, imem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (next_pc !== RESET_PC || imem_req !== 1'b0) begin
      errors++; $display("FAIL rmid_boot got next_pc=%h req=%b exp %h 0", next_pc, imem_req, RESET_PC);
    end
    cyc(1'b0, 32'h0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL rmid_first_req got req=%b addr=%h exp 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_perf();
    int ng, pushes, stalls;
    logic [31:0] exp_f, exp_s;
    do_reset();
    ng = 0; pushes = 0; stalls = 0;
    for (int i = 0; i < 40; i++) begin
      mem_gnt = (ng < 10);
      cyc(1'b0, 32'h0, (i == 0 || i == 1 || i == 3) ? 1 : 2);
      if (imem_req && imem_gnt) ng++;
      if (imem_rvalid) pushes++;
      if (dec_ready && !dec_valid) stalls++;
    end
    @(negedge clk);
`ifdef FETCH_PERF_EN
    exp_f = 32'(pushes); exp_s = 32'(stalls);
`else
    exp_f = 32'd0; exp_s = 32'd0;
`endif
    checks++;
    if (perf_fetch_cnt !== exp_f || perf_stall_cnt !== exp_s) begin
      errors++; $display("FAIL perf got %0d/%0d exp %0d/%0d", perf_fetch_cnt, perf_stall_cnt, exp_f, exp_s);
    end
  endtask

  task automatic test_random();
    int m_cnt;
    bit m_out, m_stale, r, exp_req;
    logic [31:0] m_fetch, m_del, t;
    do_reset();
    m_cnt = 0; m_out = 1'b0; m_stale = 1'b0; m_fetch = RESET_PC; m_del = RESET_PC;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           t = 32'($urandom_range(0, 4095));
      mem_gnt = ($urandom_range(0, 9) < 7);
      mem_lat = $urandom_range(1, 3);
      cyc(r, t, ($urandom_range(0, 2) != 0) ? 1 : 0);
      exp_req = !m_out && !r && (m_cnt < DEPTH);
      checks++;
      if (dec_valid !== (m_cnt != 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, dec_valid, m_cnt != 0);
      end
      if (m_cnt != 0) begin
        checks++;
        if (dec_pc !== m_del || dec_instr !== f(m_del)) begin
          errors++; $display("FAIL rnd_dec cyc %0d got %h/%h exp %h/%h", i, dec_pc, dec_instr, m_del, f(m_del));
        end
      end
      checks++;
      if (imem_req !== exp_req) begin
        errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, imem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (imem_addr !== m_fetch) begin
          errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, imem_addr, m_fetch);
        end
      end
      if (r) begin
        checks++;
        if (next_pc !== (t & 32'hFFFF_FFFC)) begin
          errors++; $display("FAIL rnd_next_pc cyc %0d got %h exp %h", i, next_pc, t & 32'hFFFF_FFFC);
        end
        m_cnt = 0; m_fetch = t & 32'hFFFF_FFFC; m_del = m_fetch;
        if (imem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
        else if (m_out)  m_stale = 1'b1;
      end else begin
        if (imem_rvalid) begin
          if (!m_stale) m_cnt++;
          m_out = 1'b0; m_stale = 1'b0;
        end
        if (dec_valid && dec_ready) begin m_cnt--; m_del = m_del + 32'd4; end
        if (imem_req && imem_gnt) begin m_out = 1'b1; m_fetch = m_fetch + 32'd4; end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_redirect_wait();
    test_redirect_rvalid();
    test_reset_mid();
    test_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
